mult_seq_w: RTL and testbench
=============================

# mult_seq_w

Parametrised sequential shift-add multiplier producing a 2·WIDTH-bit product as HI/LO halves, with a per-operation signed/unsigned mode and a START/DONE handshake. It is the area-reduced successor to the combinational array multiplier: one WIDTH-bit adder is reused over WIDTH cycles instead of WIDTH−1 chained adders. It sits beside the ALU and serves MUL (signed) and MULU (unsigned) operations, with the control unit stalling on BUSY.

## Interface
- WIDTH, 32, operand width in bits; legal range 4..64.
- CLK  in  1  rising-edge clock.
- RST  in  1  asynchronous, active-high reset.
- START  in  1  request; sampled only in IDLE.
- SIGNED  in  1  1 = two's-complement operands, 0 = unsigned; sampled with START.
- A  in  WIDTH  multiplicand; sampled with START.
- B  in  WIDTH  multiplier; sampled with START.
- BUSY  out  1  high while an operation is in flight (CALC or FIX).
- DONE  out  1  one-cycle pulse when HI/LO carry a new result.
- HI  out  WIDTH  upper half of product.
- LO  out  WIDTH  lower half of product.

## Operation
- States: IDLE, CALC, FIX. Bit counter width is clog2(WIDTH+1).
- IDLE, START=1 at an edge: latch the magnitudes |A| and |B| (two's-complement negation when SIGNED=1 and the MSB is set; raw value otherwise). Latch neg = SIGNED & (A[MSB] ^ B[MSB]). Clear the accumulator (WIDTH+1 bits) and the counter. Go to CALC.
- CALC, each edge: if the multiplier register LSB=1, acc = acc + mcnd (WIDTH+1-bit sum including carry). Then shift {acc, mplr} right by one; the carry enters the acc MSB and the acc LSB enters the mplr MSB. Increment the counter. After the WIDTH-th CALC edge, go to FIX.
- FIX, one edge: P = {acc[WIDTH-1:0], mplr}; if neg, P = ~P + 1 (2·WIDTH bits, wraps). Register HI = P[2W-1:W] and LO = P[W-1:0]. Go to IDLE and set DONE for one cycle.
- Magnitudes are unsigned WIDTH-bit values, so −2^(WIDTH−1) is handled exactly. (−2^(W−1))·(−2^(W−1)) = 2^(2W−2) fits the signed 2W-bit range.
- Zero operand with a sign mismatch: negating 0 gives 0; no negative zero.
- START in CALC or FIX is ignored; there is no queueing. A, B and SIGNED may change freely after the accept edge.
- HI/LO hold the last result until the next FIX edge. They never show partial products.

## Timing
- Reset (async assert, any state): state=IDLE, BUSY=0, DONE=0, HI=0, LO=0, counter=0, acc=0. Any operation in flight is discarded; no DONE follows.
- Deassertion of RST is synchronous to CLK at the integrating level. The first edge with RST low may accept START.
- Accept at edge t0: BUSY=1 from t0 through the FIX edge at t0+WIDTH+1, then BUSY=0.
- DONE=1 and new HI/LO are valid in the cycle after edge t0+WIDTH+1. Latency is WIDTH+1 edges, which is 33 for WIDTH=32.
- DONE is high exactly one cycle. The state is IDLE during that cycle, so a START during the DONE cycle is accepted back-to-back; throughput is one result per WIDTH+2 cycles.
- BUSY and DONE are registered, not decoded from inputs.

## Test plan
- WIDTH=32, unsigned 0xFFFFFFFF×0xFFFFFFFF -> after 33 edges DONE=1, HI=0xFFFFFFFE, LO=0x00000001. BUSY is high for exactly 33 cycles.
- WIDTH=32, signed: −3×5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1. −1×−1 -> HI=0, LO=1. 0×−7 -> HI=0, LO=0. 0x80000000×0x80000000 -> HI=0x40000000, LO=0.
- WIDTH=8 instance, signed 0x80×0x7F -> HI=0xC0, LO=0x80. Unsigned 0x80×0x80 -> HI=0x40, LO=0x00. Latency is 9 edges.
- START pulses with other operands on every cycle while BUSY -> ignored. Exactly one DONE appears, carrying the first operands' product.
- START asserted during the DONE cycle with new operands -> second DONE follows 34 cycles after the first. The first HI/LO stay stable until the second DONE.
- RST pulsed mid-CALC (cycle 10) -> HI/LO/BUSY/DONE are 0 immediately and asynchronously, with no DONE afterwards. A fresh START after release gives a correct product, e.g. 7×6 -> LO=42.

Source files
------------

// File: rtl/mult_seq_w_if.sv
// mult_seq_w_if: start/done handshake, operands and product halves of the sequential multiplier
interface mult_seq_w_if #(parameter int WIDTH = 32);
   logic start, is_signed, busy, done;
   logic [WIDTH-1:0] a, b, hi, lo;
   modport master (output start, is_signed, a, b, input busy, done, hi, lo);
   modport slave (input start, is_signed, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/mult_seq_w.sv
// mult_seq_w: shift-add multiplier, one adder reused over WIDTH cycles, signed/unsigned per operation
module mult_seq_w #(parameter int WIDTH = 32) (
   input logic clk,
   input logic rst,
   mult_seq_w_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);
   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
   state_t state;
   logic [WIDTH-1:0] mcnd, mplr, mag_a, mag_b;
   logic [WIDTH:0] acc, sum;
   logic [CW-1:0] cnt;
   logic neg;
   logic [2*WIDTH-1:0] prod, prod_s;
   // operate on magnitudes so -2^(W-1) needs no extra bit; sign is restored in FIX
   always_comb begin
      mag_a = (bus.is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
      mag_b = (bus.is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
      sum = acc + {1'b0, mcnd & {WIDTH{mplr[0]}}};
      prod = {acc[WIDTH-1:0], mplr};
      prod_s = neg ? -prod : prod;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         mcnd <= '0;
         mplr <= '0;
         acc <= '0;
         cnt <= '0;
         neg <= 1'b0;
         bus.busy <= 1'b0;
         bus.done <= 1'b0;
         bus.hi <= '0;
         bus.lo <= '0;
      end else begin
         bus.done <= 1'b0;
         case (state)
            IDLE: if (bus.start) begin
               mcnd <= mag_a;
               mplr <= mag_b;
               neg <= bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
               acc <= '0;
               cnt <= '0;
               bus.busy <= 1'b1;
               state <= CALC;
            end
            CALC: begin
               acc <= {1'b0, sum[WIDTH:1]};
               mplr <= {sum[0], mplr[WIDTH-1:1]};
               cnt <= cnt + 1'b1;
               state <= (cnt == CW'(WIDTH - 1)) ? FIX : CALC;
            end
            FIX: begin
               bus.hi <= prod_s[2*WIDTH-1:WIDTH];
               bus.lo <= prod_s[WIDTH-1:0];
               bus.done <= 1'b1;
               bus.busy <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mult_seq_w.sv
// tb_mult_seq_w: directed scoreboard bench for 32- and 8-bit instances of mult_seq_w
module tb_mult_seq_w;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   logic [63:0] q[$];
   mult_seq_w_if #(.WIDTH(32)) b32();
   mult_seq_w_if #(.WIDTH(8)) b8();
   mult_seq_w #(.WIDTH(32)) u32 (.clk(clk), .rst(rst), .bus(b32));
   mult_seq_w #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .bus(b8));
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   function automatic logic dn(input bit w8);
      return w8 ? b8.done : b32.done;
   endfunction
   function automatic logic bsy(input bit w8);
      return w8 ? b8.busy : b32.busy;
   endfunction
   function automatic logic [63:0] res(input bit w8);
      return w8 ? {48'b0, b8.hi, b8.lo} : {b32.hi, b32.lo};
   endfunction
   function automatic logic [63:0] model(input bit w8, input logic [31:0] x, input logic [31:0] y, input logic s);
      logic [63:0] p;
      logic [15:0] p8;
      if (w8) begin
         if (s) p8 = $signed(x[7:0]) * $signed(y[7:0]);
         else p8 = x[7:0] * y[7:0];
         p = {48'b0, p8};
      end else if (s) p = $signed(x) * $signed(y);
      else p = x * y;
      return p;
   endfunction
   task automatic launch(input bit w8, input logic [31:0] x, input logic [31:0] y, input logic s, input logic [63:0] exp);
      if (w8) begin
         b8.start = 1'b1; b8.a = x[7:0]; b8.b = y[7:0]; b8.is_signed = s;
      end else begin
         b32.start = 1'b1; b32.a = x; b32.b = y; b32.is_signed = s;
      end
      q.push_back(exp);
      @(posedge clk); #1;
      b8.start = 1'b0;
      b32.start = 1'b0;
   endtask
   task automatic finish(input bit w8, input string tag, input bit spam);
      int e = 0;
      int bc;
      bit moved = 0;
      logic [63:0] held, exp;
      bc = int'(bsy(w8));
      held = res(w8);
      while (!dn(w8) && e < 200) begin
         @(posedge clk); #1;
         e++;
         if (!dn(w8)) begin
            bc += int'(bsy(w8));
            if (res(w8) !== held) moved = 1;
            if (spam) begin
               b32.start = 1'b1; b32.a = $urandom; b32.b = $urandom; b32.is_signed = 1'($urandom);
            end
         end
      end
      b32.start = 1'b0;
      b8.start = 1'b0;
      chk({tag, "_lat"}, 64'(e), w8 ? 64'd9 : 64'd33);
      chk({tag, "_busy"}, 64'(bc), w8 ? 64'd9 : 64'd33);
      chk({tag, "_hold"}, 64'(moved), 64'd0);
      exp = (q.size() > 0) ? q.pop_front() : 64'hDEAD;
      chk({tag, "_prod"}, res(w8), exp);
   endtask
   initial begin
      int t1, extra;
      logic [31:0] x, y;
      logic s;
      b32.start = 1'b0; b32.a = '0; b32.b = '0; b32.is_signed = 1'b0;
      b8.start = 1'b0; b8.a = '0; b8.b = '0; b8.is_signed = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      chk("rst32", {b32.busy, b32.done, 30'b0, b32.hi | b32.lo}, 64'd0);
      chk("rst8", {b8.busy, b8.done, 54'b0, b8.hi | b8.lo}, 64'd0);
      launch(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, {32'hFFFFFFFE, 32'h00000001});
      finish(0, "umax", 0);
      @(posedge clk); #1;
      chk("done_pulse", 64'(b32.done), 64'd0);
      launch(0, -32'sd3, 32'd5, 1, {32'hFFFFFFFF, 32'hFFFFFFF1});
      finish(0, "m3x5", 0);
      launch(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 64'd1);
      finish(0, "m1xm1", 0);
      launch(0, 32'd0, -32'sd7, 1, 64'd0);
      finish(0, "zero_neg", 0);
      launch(0, 32'h80000000, 32'h80000000, 1, {32'h40000000, 32'h0});
      finish(0, "minxmin", 0);
      launch(1, 32'h80, 32'h7F, 1, 64'hC080);
      finish(1, "w8_s", 0);
      launch(1, 32'h80, 32'h80, 0, 64'h4000);
      finish(1, "w8_u", 0);
      for (int i = 0; i < 4; i++) begin
         x = $urandom; y = $urandom; s = 1'(i);
         launch(i[1], x, y, s, model(i[1], x, y, s));
         finish(i[1], $sformatf("rnd%0d", i), 0);
      end
      launch(0, 32'd1234, 32'd5678, 0, 64'd7006652);
      finish(0, "spam", 1);
      extra = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (b32.done || b32.busy) extra++;
      end
      chk("spam_quiet", 64'(extra), 64'd0);
      launch(0, 32'd100000, 32'd300000, 0, 64'd30000000000);
      finish(0, "b2b_a", 0);
      t1 = cyc;
      launch(0, -32'sd9, 32'd11, 1, model(0, -32'sd9, 32'd11, 1));
      finish(0, "b2b_b", 0);
      chk("b2b_gap", 64'(cyc - t1), 64'd34);
      launch(0, 32'd123, 32'd456, 1, 64'd0);
      void'(q.pop_back());
      repeat (10) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("async_rst", {b32.busy, b32.done, 30'b0, b32.hi | b32.lo}, 64'd0);
      @(negedge clk) rst = 1'b0;
      extra = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (b32.done || b32.busy) extra++;
      end
      chk("rst_no_done", 64'(extra), 64'd0);
      launch(0, 32'd7, 32'd6, 0, 64'd42);
      finish(0, "post_rst", 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
